// File: rtl/uart_apb_sequencer.sv
// uart_apb_sequencer: APB master that programs one CoreUARTapb, then polls
// its status register and moves bytes between the UART data registers and
// two single-entry byte holding registers exposed as valid/ready streams.
//
// Handshakes: a byte moves on a stream only on a clock edge where both valid
// and ready are 1. The producer holds valid and data stable until that edge.
// valid never waits for ready. Here tx_* is consumed and rx_* is produced.
module uart_apb_sequencer #(
    parameter int unsigned POLL_GAP    = 4,
    parameter logic [4:0]  ADDR_TXDATA = 5'h00,
    parameter logic [4:0]  ADDR_RXDATA = 5'h04,
    parameter logic [4:0]  ADDR_CTRL1  = 5'h08,
    parameter logic [4:0]  ADDR_CTRL2  = 5'h0C,
    parameter logic [4:0]  ADDR_STATUS = 5'h10
) (
    input  logic        PCLK,
    input  logic        PRESETN,
    output logic        PSEL,
    output logic        PENABLE,
    output logic        PWRITE,
    output logic [4:0]  PADDR,
    output logic [7:0]  PWDATA,
    input  logic [7:0]  PRDATA,
    input  logic        PREADY,
    input  logic        cfg_start,
    input  logic [12:0] cfg_baud,
    input  logic        cfg_bit8,
    input  logic        cfg_par_en,
    input  logic        cfg_odd,
    output logic        configured,
    input  logic        tx_valid,
    input  logic [7:0]  tx_data,
    output logic        tx_ready,
    output logic        rx_valid,
    output logic [7:0]  rx_data,
    input  logic        rx_ready,
    output logic [2:0]  err,
    input  logic        err_clr,
    output logic [2:0]  dbg_state
);

    typedef enum logic [2:0] {
        S_UNCFG = 3'd0,
        S_CFG1  = 3'd1,
        S_CFG2  = 3'd2,
        S_POLL  = 3'd3,
        S_RXRD  = 3'd4,
        S_TXWR  = 3'd5,
        S_GAP   = 3'd6
    } state_t;

    localparam logic [7:0] GAP_LAST = 8'(POLL_GAP - 1);

    state_t      state;
    logic [12:0] baud_q;
    logic        bit8_q;
    logic        par_en_q;
    logic        odd_q;
    logic        cfg_pend;     // reprogram requested, waiting for the bus to go idle
    logic        rr_rx_first;  // when RX and TX both have work, which goes next
    logic [7:0]  gap_cnt;
    logic [7:0]  tx_hold;

    logic        xfer_done;
    logic        cfg_pending;
    logic        rx_cand;
    logic        tx_cand;
    logic [2:0]  err_set;
    logic [4:0]  setup_addr;
    logic        setup_write;
    logic [7:0]  setup_data;

    assign dbg_state   = state;
    assign xfer_done   = PSEL & PENABLE & PREADY;
    assign cfg_pending = cfg_pend | cfg_start;
    // Candidates are only meaningful on the cycle a STATUS read completes.
    assign rx_cand     = PRDATA[1] & ~rx_valid;
    assign tx_cand     = PRDATA[0] & ~tx_ready;
    assign err_set     = (state == S_POLL && xfer_done) ? PRDATA[4:2] : 3'b000;

    // Address, direction and write data for the transfer the current state issues.
    always_comb begin
        setup_addr  = ADDR_STATUS;
        setup_write = 1'b0;
        setup_data  = 8'h00;
        case (state)
            S_CFG1: begin
                setup_addr  = ADDR_CTRL1;
                setup_write = 1'b1;
                setup_data  = baud_q[7:0];
            end
            S_CFG2: begin
                setup_addr  = ADDR_CTRL2;
                setup_write = 1'b1;
                setup_data  = {baud_q[12:8], odd_q, par_en_q, bit8_q};
            end
            S_RXRD: setup_addr = ADDR_RXDATA;
            S_TXWR: begin
                setup_addr  = ADDR_TXDATA;
                setup_write = 1'b1;
                setup_data  = tx_hold;
            end
            default: setup_addr = ADDR_STATUS;
        endcase
    end

    // Sequencer FSM with the APB engine, holding registers and sticky errors.
    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            state       <= S_UNCFG;
            PSEL        <= 1'b0;
            PENABLE     <= 1'b0;
            PWRITE      <= 1'b0;
            PADDR       <= 5'h00;
            PWDATA      <= 8'h00;
            configured  <= 1'b0;
            tx_ready    <= 1'b1;
            tx_hold     <= 8'h00;
            rx_valid    <= 1'b0;
            rx_data     <= 8'h00;
            err         <= 3'b000;
            baud_q      <= 13'h0000;
            bit8_q      <= 1'b0;
            par_en_q    <= 1'b0;
            odd_q       <= 1'b0;
            cfg_pend    <= 1'b0;
            rr_rx_first <= 1'b1;
            gap_cnt     <= 8'h00;
        end else begin
            // New configuration is captured at once; programming waits for an idle bus.
            if (cfg_start) begin
                baud_q     <= cfg_baud;
                bit8_q     <= cfg_bit8;
                par_en_q   <= cfg_par_en;
                odd_q      <= cfg_odd;
                configured <= 1'b0;
                cfg_pend   <= 1'b1;
            end

            if (tx_valid && tx_ready) begin
                tx_hold  <= tx_data;
                tx_ready <= 1'b0;
            end

            if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end

            // A fresh error report wins over a clear in the same cycle.
            if (|err_set) begin
                err <= err | err_set;
            end else if (err_clr) begin
                err <= 3'b000;
            end

            case (state)
                S_UNCFG: begin
                    if (cfg_pending) begin
                        state    <= S_CFG1;
                        cfg_pend <= 1'b0;
                    end
                end

                S_GAP: begin
                    if (cfg_pending) begin
                        state    <= S_CFG1;
                        cfg_pend <= 1'b0;
                    end else if (gap_cnt == GAP_LAST) begin
                        state <= S_POLL;
                    end else begin
                        gap_cnt <= gap_cnt + 8'd1;
                    end
                end

                default: begin
                    if (!PSEL) begin
                        // Bus idle: either divert to reprogramming or start SETUP.
                        if (cfg_pending) begin
                            state    <= S_CFG1;
                            cfg_pend <= 1'b0;
                        end else begin
                            PSEL    <= 1'b1;
                            PENABLE <= 1'b0;
                            PADDR   <= setup_addr;
                            PWRITE  <= setup_write;
                            PWDATA  <= setup_data;
                        end
                    end else if (!PENABLE) begin
                        PENABLE <= 1'b1;
                    end else if (PREADY) begin
                        // Completion: data effects always land, even if a reprogram follows.
                        PSEL    <= 1'b0;
                        PENABLE <= 1'b0;
                        if (state == S_RXRD) begin
                            rx_data  <= PRDATA;
                            rx_valid <= 1'b1;
                        end
                        if (state == S_TXWR) begin
                            tx_ready <= 1'b1;
                        end

                        if (cfg_pending) begin
                            state    <= S_CFG1;
                            cfg_pend <= 1'b0;
                        end else begin
                            case (state)
                                S_CFG1: state <= S_CFG2;
                                S_CFG2: begin
                                    configured <= 1'b1;
                                    state      <= S_POLL;
                                end
                                S_POLL: begin
                                    if (rx_cand && tx_cand) begin
                                        state       <= rr_rx_first ? S_RXRD : S_TXWR;
                                        rr_rx_first <= ~rr_rx_first;
                                    end else if (rx_cand) begin
                                        state <= S_RXRD;
                                    end else if (tx_cand) begin
                                        state <= S_TXWR;
                                    end else if (POLL_GAP == 0) begin
                                        state <= S_POLL;
                                    end else begin
                                        state   <= S_GAP;
                                        gap_cnt <= 8'h00;
                                    end
                                end
                                default: state <= S_POLL;
                            endcase
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_apb_sequencer.sv
// Directed bench for uart_apb_sequencer: a small UART register model answers
// APB reads, a monitor logs every non-STATUS transfer, and each scenario task
// compares the log and the stream outputs against hand-computed values.
module tb_uart_apb_sequencer;

    logic        PCLK = 1'b0;
    logic        PRESETN;
    logic        PSEL, PENABLE, PWRITE;
    logic [4:0]  PADDR;
    logic [7:0]  PWDATA;
    logic [7:0]  PRDATA;
    logic        PREADY;
    logic        cfg_start;
    logic [12:0] cfg_baud;
    logic        cfg_bit8, cfg_par_en, cfg_odd;
    logic        configured;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic [2:0]  err;
    logic        err_clr;
    logic [2:0]  dbg_state;

    logic [7:0]  status_val;
    logic [7:0]  rxdata_val;

    int total = 0;
    int bad   = 0;

    // Observed transfers {write, addr, data}; STATUS polls are not logged.
    logic [13:0] obs_q[$];
    logic [13:0] exp_q[$];

    uart_apb_sequencer dut (
        .PCLK(PCLK), .PRESETN(PRESETN),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY),
        .cfg_start(cfg_start), .cfg_baud(cfg_baud), .cfg_bit8(cfg_bit8),
        .cfg_par_en(cfg_par_en), .cfg_odd(cfg_odd), .configured(configured),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
        .err(err), .err_clr(err_clr), .dbg_state(dbg_state)
    );

    // Clock
    always #5 PCLK = ~PCLK;

    // UART register read model
    assign PRDATA = (PADDR == 5'h10) ? status_val :
                    (PADDR == 5'h04) ? rxdata_val : 8'h00;

    // Transfer monitor
    always @(negedge PCLK) begin
        if (PRESETN && PSEL && PENABLE && PREADY && PADDR != 5'h10)
            obs_q.push_back({PWRITE, PADDR, (PWRITE ? PWDATA : PRDATA)});
    end

    // Watchdog
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge PCLK);
    endtask

    task automatic test_reset;
        PRESETN = 1'b0; cfg_start = 1'b0; cfg_baud = '0; cfg_bit8 = 1'b0;
        cfg_par_en = 1'b0; cfg_odd = 1'b0; tx_valid = 1'b0; tx_data = 8'h00;
        rx_ready = 1'b0; err_clr = 1'b0; PREADY = 1'b1;
        status_val = 8'h00; rxdata_val = 8'h00;
        wait_cycles(3);
        total++; if ({PSEL, PENABLE, PWRITE} !== 3'b000) begin bad++;
            $display("FAIL reset_ctl got=%b required=000", {PSEL, PENABLE, PWRITE}); end
        total++; if (PADDR !== 5'h00 || PWDATA !== 8'h00) begin bad++;
            $display("FAIL reset_bus got=%h/%h required=00/00", PADDR, PWDATA); end
        total++; if (configured !== 1'b0 || tx_ready !== 1'b1) begin bad++;
            $display("FAIL reset_cfg_tx got=%b%b required=01", configured, tx_ready); end
        total++; if (rx_valid !== 1'b0 || rx_data !== 8'h00 || err !== 3'b000) begin bad++;
            $display("FAIL reset_rx_err got=%b/%h/%b required=0/00/000", rx_valid, rx_data, err); end
        PRESETN = 1'b1;
        wait_cycles(6);
        total++; if (PSEL !== 1'b0) begin bad++;
            $display("FAIL uncfg_idle got PSEL=%b required=0", PSEL); end
    endtask

    task automatic test_config(input logic [12:0] baud, input logic b8, input logic pe,
                               input logic od, input logic [7:0] c1, input logic [7:0] c2);
        int n;
        obs_q.delete();
        cfg_baud = baud; cfg_bit8 = b8; cfg_par_en = pe; cfg_odd = od; cfg_start = 1'b1;
        @(negedge PCLK);
        cfg_start = 1'b0;
        total++; if (configured !== 1'b0) begin bad++;
            $display("FAIL cfg_drop got=%b required=0", configured); end
        n = 0;
        while (configured !== 1'b1 && n < 100) begin @(negedge PCLK); n++; end
        total++; if (configured !== 1'b1) begin bad++;
            $display("FAIL cfg_done got=%b required=1", configured); end
        exp_q.delete();
        exp_q.push_back({1'b1, 5'h08, c1});
        exp_q.push_back({1'b1, 5'h0C, c2});
        total++; if (obs_q.size() !== 2) begin bad++;
            $display("FAIL cfg_count got=%0d required=2", obs_q.size()); end
        for (int i = 0; i < 2; i++) begin
            if (i < obs_q.size()) begin
                total++; if (obs_q[i] !== exp_q[i]) begin bad++;
                    $display("FAIL cfg_xfer[%0d] got=%h required=%h", i, obs_q[i], exp_q[i]); end
            end
        end
    endtask

    task automatic test_tx;
        int n;
        bit found;
        obs_q.delete();
        tx_data = 8'h5A; tx_valid = 1'b1;
        @(negedge PCLK);
        tx_valid = 1'b0;
        total++; if (tx_ready !== 1'b0) begin bad++;
            $display("FAIL tx_accept got=%b required=0", tx_ready); end
        status_val = 8'h01;
        n = 0; found = 0;
        while (!found && n < 100) begin
            @(negedge PCLK); n++;
            if (PSEL && PENABLE && PREADY && PWRITE && PADDR == 5'h00) found = 1;
        end
        total++; if (!found) begin bad++;
            $display("FAIL tx_timeout got=no_write required=write"); end
        total++; if (tx_ready !== 1'b0) begin bad++;
            $display("FAIL tx_ready_early got=%b required=0", tx_ready); end
        status_val = 8'h00;
        @(negedge PCLK);
        total++; if (tx_ready !== 1'b1) begin bad++;
            $display("FAIL tx_ready_after got=%b required=1", tx_ready); end
        total++; if (obs_q.size() !== 1 || obs_q[0] !== {1'b1, 5'h00, 8'h5A}) begin bad++;
            $display("FAIL tx_xfer got n=%0d first=%h required n=1 first=%h",
                     obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : 14'h0, {1'b1, 5'h00, 8'h5A}); end
    endtask

    task automatic test_rx;
        int n;
        bit found;
        obs_q.delete();
        rxdata_val = 8'hC3; status_val = 8'h02;
        n = 0; found = 0;
        while (!found && n < 100) begin
            @(negedge PCLK); n++;
            if (PSEL && PENABLE && PREADY && !PWRITE && PADDR == 5'h04) found = 1;
        end
        total++; if (!found) begin bad++;
            $display("FAIL rx_timeout got=no_read required=read"); end
        total++; if (rx_valid !== 1'b0) begin bad++;
            $display("FAIL rx_valid_early got=%b required=0", rx_valid); end
        @(negedge PCLK);
        rxdata_val = 8'h99;
        total++; if (rx_valid !== 1'b1 || rx_data !== 8'hC3) begin bad++;
            $display("FAIL rx_capture got=%b/%h required=1/c3", rx_valid, rx_data); end
        wait_cycles(40);
        total++; if (rx_valid !== 1'b1 || rx_data !== 8'hC3) begin bad++;
            $display("FAIL rx_hold got=%b/%h required=1/c3", rx_valid, rx_data); end
        total++; if (obs_q.size() !== 1 || obs_q[0] !== {1'b0, 5'h04, 8'hC3}) begin bad++;
            $display("FAIL rx_reads got n=%0d required n=1 of %h", obs_q.size(), {1'b0, 5'h04, 8'hC3}); end
        status_val = 8'h00;
        rx_ready = 1'b1;
        @(negedge PCLK);
        rx_ready = 1'b0;
        total++; if (rx_valid !== 1'b0) begin bad++;
            $display("FAIL rx_consume got=%b required=0", rx_valid); end
    endtask

    task automatic test_back_to_back;
        int n;
        obs_q.delete();
        rxdata_val = 8'h22; tx_data = 8'h11; tx_valid = 1'b1; rx_ready = 1'b1;
        @(negedge PCLK);
        status_val = 8'h03;
        n = 0;
        while (obs_q.size() < 4 && n < 400) begin @(negedge PCLK); n++; end
        total++; if (obs_q.size() < 4) begin bad++;
            $display("FAIL rr_timeout got=%0d required=4", obs_q.size()); end
        exp_q.delete();
        exp_q.push_back({1'b0, 5'h04, 8'h22});
        exp_q.push_back({1'b1, 5'h00, 8'h11});
        exp_q.push_back({1'b0, 5'h04, 8'h22});
        exp_q.push_back({1'b1, 5'h00, 8'h11});
        for (int i = 0; i < 4; i++) begin
            if (i < obs_q.size()) begin
                total++; if (obs_q[i] !== exp_q[i]) begin bad++;
                    $display("FAIL rr_order[%0d] got=%h required=%h", i, obs_q[i], exp_q[i]); end
            end
        end
        // Drain: flush the reloaded TX byte and any RX byte still in flight.
        tx_valid = 1'b0; status_val = 8'h01;
        wait_cycles(60);
        status_val = 8'h00;
        wait_cycles(20);
        rx_ready = 1'b0;
        obs_q.delete();
    endtask

    task automatic test_wait_states;
        int n;
        bit found;
        obs_q.delete();
        tx_data = 8'h77; tx_valid = 1'b1;
        @(negedge PCLK);
        tx_valid = 1'b0; status_val = 8'h01;
        n = 0; found = 0;
        while (!found && n < 100) begin
            @(negedge PCLK); n++;
            if (PSEL && !PENABLE && PWRITE && PADDR == 5'h00) found = 1;
        end
        total++; if (!found) begin bad++;
            $display("FAIL ws_timeout got=no_setup required=setup"); end
        PREADY = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge PCLK);
            total++; if (!(PSEL && PENABLE && PWRITE && PADDR == 5'h00 && PWDATA == 8'h77)) begin bad++;
                $display("FAIL ws_stable[%0d] got=%b%b%b/%h/%h required=111/00/77",
                         i, PSEL, PENABLE, PWRITE, PADDR, PWDATA); end
            if (i == 2) begin
                @(posedge PCLK);
                #1 PREADY = 1'b1;
            end
        end
        @(negedge PCLK);
        status_val = 8'h00;
        total++; if (PSEL !== 1'b0 || PENABLE !== 1'b0) begin bad++;
            $display("FAIL ws_release got=%b%b required=00", PSEL, PENABLE); end
        total++; if (obs_q.size() !== 1 || obs_q[0] !== {1'b1, 5'h00, 8'h77}) begin bad++;
            $display("FAIL ws_single got n=%0d required n=1 of %h", obs_q.size(), {1'b1, 5'h00, 8'h77}); end
        wait_cycles(20);
    endtask

    task automatic test_err;
        int n;
        bit found;
        total++; if (err !== 3'b000) begin bad++;
            $display("FAIL err_initial got=%b required=000", err); end
        status_val = 8'h14;
        n = 0; found = 0;
        while (!found && n < 100) begin
            @(negedge PCLK); n++;
            if (PSEL && PENABLE && PREADY && PADDR == 5'h10) found = 1;
        end
        err_clr = 1'b1;
        @(negedge PCLK);
        err_clr = 1'b0;
        total++; if (!found || err !== 3'b101) begin bad++;
            $display("FAIL err_set_vs_clr got=%b required=101", err); end
        status_val = 8'h00;
        wait_cycles(20);
        total++; if (err !== 3'b101) begin bad++;
            $display("FAIL err_sticky got=%b required=101", err); end
        status_val = 8'h08;
        wait_cycles(20);
        status_val = 8'h00;
        wait_cycles(20);
        total++; if (err !== 3'b111) begin bad++;
            $display("FAIL err_or got=%b required=111", err); end
        err_clr = 1'b1;
        @(negedge PCLK);
        err_clr = 1'b0;
        total++; if (err !== 3'b000) begin bad++;
            $display("FAIL err_clear got=%b required=000", err); end
    endtask

    task automatic test_reset_mid;
        int n;
        n = 0;
        while (PSEL !== 1'b1 && n < 100) begin @(negedge PCLK); n++; end
        total++; if (PSEL !== 1'b1) begin bad++;
            $display("FAIL rst_mid_timeout got=%b required=1", PSEL); end
        PRESETN = 1'b0;
        #1;
        total++; if (PSEL !== 1'b0 || PENABLE !== 1'b0 || configured !== 1'b0) begin bad++;
            $display("FAIL rst_mid got=%b%b%b required=000", PSEL, PENABLE, configured); end
        @(negedge PCLK);
        PRESETN = 1'b1;
        wait_cycles(5);
        total++; if (PSEL !== 1'b0) begin bad++;
            $display("FAIL rst_mid_idle got=%b required=0", PSEL); end
    endtask

    initial begin
        test_reset();
        test_config(13'h1A5, 1'b1, 1'b1, 1'b0, 8'hA5, 8'h0B);
        test_tx();
        test_rx();
        test_back_to_back();
        test_wait_states();
        test_err();
        test_config(13'h1FFF, 1'b0, 1'b0, 1'b1, 8'hFF, 8'hFC);
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
